// File: rtl/sim_run_monitor.sv
// Run controller and checker for the processor bench: sequences the core reset,
// counts run cycles and judges the run from register-file write-back traffic.
module sim_run_monitor #(
  parameter int                    DATA_WIDTH     = 32,
  parameter int                    REG_ADDR_WIDTH = 5,
  parameter int                    CNT_WIDTH      = 16,
  parameter int                    RESET_CYCLES   = 2,
  parameter int                    MAX_CYCLES     = 20,
  parameter int                    WATCH_REG      = 15,
  parameter logic [DATA_WIDTH-1:0] EXPECT_VALUE   = '0,
  parameter int                    CHECK_MODE     = 0
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  input  logic                      rf_we,
  input  logic [REG_ADDR_WIDTH-1:0] rf_waddr,
  input  logic [DATA_WIDTH-1:0]     rf_wdata,
  output logic                      core_reset,
  output logic                      running,
  output logic                      done,
  output logic                      pass,
  output logic                      timeout,
  output logic [CNT_WIDTH-1:0]      cycle_count,
  output logic [CNT_WIDTH-1:0]      write_count,
  output logic [DATA_WIDTH-1:0]     last_value
);

  localparam int HOLD_W = (RESET_CYCLES < 1) ? 1 : $clog2(RESET_CYCLES + 1);

  localparam logic [HOLD_W-1:0]         HOLD_LAST = HOLD_W'(RESET_CYCLES);
  localparam logic [CNT_WIDTH-1:0]      CNT_SAT   = '1;
  localparam logic [CNT_WIDTH-1:0]      CYC_LAST  = CNT_WIDTH'(MAX_CYCLES - 1);
  localparam logic [REG_ADDR_WIDTH-1:0] WATCH     = REG_ADDR_WIDTH'(WATCH_REG);

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RUN     = 3'd1,
    ST_PASS    = 3'd2,
    ST_FAIL    = 3'd3,
    ST_TIMEOUT = 3'd4
  } state_t;

  state_t               state;
  logic [HOLD_W-1:0]    hold_cnt;
  logic                 valid_write;
  logic                 watch_write;
  logic                 match;
  logic                 last_tick;
  logic [CNT_WIDTH-1:0] cycle_next;
  logic [CNT_WIDTH-1:0] write_next;

  // x0 writes are architecturally discarded, so they never count or match
  assign valid_write = rf_we && (rf_waddr != '0);
  assign watch_write = valid_write && (rf_waddr == WATCH);
  assign match       = (rf_wdata == EXPECT_VALUE);
  assign last_tick   = (cycle_count == CYC_LAST);
  assign cycle_next  = (cycle_count == CNT_SAT) ? cycle_count : cycle_count + 1'b1;
  assign write_next  = (write_count == CNT_SAT) ? write_count : write_count + 1'b1;

  always_ff @(posedge clk) begin
    if (reset || (start && done)) begin
      state       <= ST_HOLD;
      hold_cnt    <= '0;
      core_reset  <= 1'b1;
      running     <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
      cycle_count <= '0;
      write_count <= '0;
      last_value  <= '0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (hold_cnt == HOLD_LAST) begin
            state      <= ST_RUN;
            core_reset <= 1'b0;
            running    <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        ST_RUN: begin
          cycle_count <= cycle_next;
          if (valid_write) begin
            write_count <= write_next;
          end
          if (watch_write) begin
            last_value <= rf_wdata;
          end
          // A decisive write on the final cycle takes priority over timeout
          if (watch_write && match) begin
            state   <= ST_PASS;
            running <= 1'b0;
            done    <= 1'b1;
            pass    <= 1'b1;
          end else if (watch_write && (CHECK_MODE == 0)) begin
            state   <= ST_FAIL;
            running <= 1'b0;
            done    <= 1'b1;
          end else if (last_tick) begin
            state   <= ST_TIMEOUT;
            running <= 1'b0;
            done    <= 1'b1;
            timeout <= 1'b1;
          end else begin
            state <= ST_RUN;
          end
        end
        default: begin
          state <= state;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sim_run_monitor.sv
// Scoreboard bench for sim_run_monitor: two instances (decide-on-first-write and
// wait-for-match) share stimulus; expectations are queued and checked on negedge.
module tb_sim_run_monitor;

  logic        clk = 1'b0;
  logic        reset, start, rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;

  logic        cr0, run0, dn0, ps0, to0, cr1, run1, dn1, ps1, to1;
  logic [15:0] cc0, wc0, cc1, wc1;
  logic [31:0] lv0, lv1;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    int           at;
    int           dut;
    string        name;
    logic [68:0]  st;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  sim_run_monitor #(.EXPECT_VALUE(32'h0000_002A), .CHECK_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .core_reset(cr0), .running(run0), .done(dn0), .pass(ps0),
    .timeout(to0), .cycle_count(cc0), .write_count(wc0), .last_value(lv0)
  );

  sim_run_monitor #(.EXPECT_VALUE(32'h0000_002A), .CHECK_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .start(start), .rf_we(rf_we), .rf_waddr(rf_waddr),
    .rf_wdata(rf_wdata), .core_reset(cr1), .running(run1), .done(dn1), .pass(ps1),
    .timeout(to1), .cycle_count(cc1), .write_count(wc1), .last_value(lv1)
  );

  wire [68:0] act0 = {cr0, run0, dn0, ps0, to0, cc0, wc0, lv0};
  wire [68:0] act1 = {cr1, run1, dn1, ps1, to1, cc1, wc1, lv1};

  // Monitor: pops every expectation due this cycle and compares it
  always @(negedge clk) begin
    exp_t        e;
    logic [68:0] a;
    while (sb.size() > 0 && sb[0].at <= cyc) begin
      e = sb.pop_front();
      a = (e.dut == 0) ? act0 : act1;
      checks++;
      if (e.at != cyc || a !== e.st) begin
        errors++;
        $display("FAIL %s dut%0d: got {cr,run,done,pass,to}=%b cc=%0d wc=%0d lv=%h, expected %b cc=%0d wc=%0d lv=%h",
                 e.name, e.dut, a[68:64], a[63:48], a[47:32], a[31:0],
                 e.st[68:64], e.st[63:48], e.st[47:32], e.st[31:0]);
      end
    end
  end

  task automatic expect_st(input int dut, input string name, input logic cr, input logic rn,
                           input logic dn, input logic ps, input logic to,
                           input int cc, input int wc, input logic [31:0] lv);
    exp_t e;
    e.at   = cyc;
    e.dut  = dut;
    e.name = name;
    e.st   = {cr, rn, dn, ps, to, 16'(cc), 16'(wc), lv};
    sb.push_back(e);
  endtask

  task automatic expect_both(input string name, input logic cr, input logic rn,
                             input logic dn, input logic ps, input logic to,
                             input int cc, input int wc, input logic [31:0] lv);
    expect_st(0, name, cr, rn, dn, ps, to, cc, wc, lv);
    expect_st(1, name, cr, rn, dn, ps, to, cc, wc, lv);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic write(input logic [4:0] a, input logic [31:0] d);
    rf_we    = 1'b1;
    rf_waddr = a;
    rf_wdata = d;
    tick(1);
    rf_we    = 1'b0;
  endtask

  // One-cycle reset then three hold edges into RUN at cycle 0
  task automatic restart_run(input string name);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    expect_both({name, "_reset"}, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
    tick(3);
    expect_both({name, "_entry"}, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
  endtask

  initial begin
    reset    = 1'b1;
    start    = 1'b0;
    rf_we    = 1'b0;
    rf_waddr = 5'd0;
    rf_wdata = 32'h0;

    // Reset sequence: core_reset for exactly RESET_CYCLES edges, RUN on the third
    tick(2);
    expect_both("reset_state", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
    reset = 1'b0;
    tick(1);
    expect_both("hold_edge1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
    tick(1);
    expect_both("hold_edge2", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
    tick(1);
    expect_both("run_entry", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
    tick(7);
    expect_both("run_cycle7", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 7, 0, 32'h0);

    // Matching watch write at RUN cycle 7
    write(5'd15, 32'h2A);
    expect_both("pass_c7", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8, 1, 32'h2A);
    write(5'd15, 32'h13);
    write(5'd3, 32'h77);
    expect_both("pass_frozen", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 8, 1, 32'h2A);

    // start in PASS restarts exactly like reset
    start = 1'b1;
    tick(1);
    start = 1'b0;
    expect_both("start_in_pass", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
    tick(3);
    expect_both("rerun_entry", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
    start = 1'b1;
    tick(1);
    start = 1'b0;
    expect_both("start_in_run", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, 0, 32'h0);

    // Mismatch: mode 0 fails, mode 1 keeps running then passes
    write(5'd15, 32'h13);
    expect_st(0, "mismatch_fail", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1, 32'h13);
    expect_st(1, "mismatch_wait", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2, 1, 32'h13);
    write(5'd15, 32'h2A);
    expect_st(0, "fail_frozen", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2, 1, 32'h13);
    expect_st(1, "wait_then_pass", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 3, 2, 32'h2A);

    // Timeout: x0 write (even of the expected value) neither counts nor matches
    restart_run("tmo");
    write(5'd0, 32'h2A);
    write(5'd5, 32'h1);
    write(5'd5, 32'h2A);
    expect_both("tmo_writes", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3, 2, 32'h0);
    tick(16);
    expect_both("tmo_cycle19", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 19, 2, 32'h0);
    tick(1);
    expect_both("timeout", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 20, 2, 32'h0);
    write(5'd15, 32'h2A);
    tick(1);
    expect_both("timeout_frozen", 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 20, 2, 32'h0);

    // Decisive write on the final RUN cycle beats timeout
    restart_run("edge");
    tick(19);
    write(5'd15, 32'h2A);
    expect_both("pass_on_last", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 20, 1, 32'h2A);

    // Reset mid-RUN, together with start
    restart_run("mid");
    write(5'd1, 32'h11);
    write(5'd2, 32'h22);
    write(5'd3, 32'h33);
    tick(2);
    expect_both("mid_cycle5", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5, 3, 32'h0);
    reset = 1'b1;
    start = 1'b1;
    tick(1);
    reset = 1'b0;
    start = 1'b0;
    expect_both("mid_reset", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0);
    tick(1);
    expect_both("mid_hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, 0, 32'h0);

    tick(2);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
